// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser: FSM state encoding,
// coin values in nickel units and the default acknowledge timeout.
package change_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WAIT_ACK,
    DONE,
    ERROR
  } state_t;

  localparam logic [4:0] NICKEL_UNITS        = 5'd1;
  localparam logic [4:0] DIME_UNITS          = 5'd2;
  localparam int         DEFAULT_ACK_TIMEOUT = 15;

endpackage

// File: rtl/ack_timer.sv
// Counts consecutive cycles spent waiting for a coin acknowledge; expired is
// raised on the LIMIT-th waiting cycle so the caller can fault on that edge.
module ack_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic expired
);

  logic [7:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_reg <= 8'd0;
    end else if (run) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  // count_reg holds the number of waiting cycles already elapsed
  assign expired = run && (count_reg == 8'(LIMIT - 1));

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: pays the owed amount with dimes first, falls back
// to nickels, waits for each hopper acknowledge and faults on timeout or empty stock.
module change_dispenser
  import change_pkg::*;
#(
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] amount,
  input  logic       dime_empty,
  input  logic       nickel_empty,
  input  logic       coin_ack,
  input  logic       clear,
  output logic       disp_n,
  output logic       disp_d,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] remaining
);

  state_t     state_reg, state_next;
  logic [4:0] remaining_reg, remaining_next;
  logic       disp_n_reg, disp_n_next;
  logic       disp_d_reg, disp_d_next;
  logic       busy_reg, done_reg, err_reg;
  logic       timer_run, timer_clr, timer_expired;

  // The timer only advances while a request is outstanding and unanswered.
  assign timer_run = (state_reg == WAIT_ACK) && !coin_ack;
  assign timer_clr = !timer_run;

  ack_timer #(
    .LIMIT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .reset  (reset),
    .run    (timer_run),
    .clr    (timer_clr),
    .expired(timer_expired)
  );

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    disp_n_next    = disp_n_reg;
    disp_d_next    = disp_d_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          remaining_next = amount;
          state_next     = (amount == 5'd0) ? DONE : SELECT;
        end
      end
      SELECT: begin
        if (remaining_reg == 5'd0) begin
          state_next = DONE;
        end else if (remaining_reg >= DIME_UNITS && !dime_empty) begin
          disp_d_next = 1'b1;
          state_next  = WAIT_ACK;
        end else if (remaining_reg >= NICKEL_UNITS && !nickel_empty) begin
          disp_n_next = 1'b1;
          state_next  = WAIT_ACK;
        end else begin
          state_next = ERROR;
        end
      end
      WAIT_ACK: begin
        // An acknowledge on the timeout cycle still counts as a paid coin.
        if (coin_ack) begin
          remaining_next = remaining_reg - (disp_d_reg ? DIME_UNITS : NICKEL_UNITS);
          disp_n_next    = 1'b0;
          disp_d_next    = 1'b0;
          state_next     = SELECT;
        end else if (timer_expired) begin
          disp_n_next = 1'b0;
          disp_d_next = 1'b0;
          state_next  = ERROR;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      ERROR: begin
        if (clear) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next  = IDLE;
        disp_n_next = 1'b0;
        disp_d_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      remaining_reg <= 5'd0;
      disp_n_reg    <= 1'b0;
      disp_d_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      disp_n_reg    <= disp_n_next;
      disp_d_reg    <= disp_d_next;
      busy_reg      <= (state_next != IDLE);
      done_reg      <= (state_next == DONE);
      err_reg       <= (state_next == ERROR);
    end
  end

  assign disp_n    = disp_n_reg;
  assign disp_d    = disp_d_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign remaining = remaining_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser; outputs are sampled 1 ns after each
// rising edge and compared against hand-computed expectations.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [4:0] amount = 5'd0;
  logic       dime_empty = 1'b0;
  logic       nickel_empty = 1'b0;
  logic       coin_ack = 1'b0;
  logic       clear = 1'b0;
  logic       disp_n, disp_d, busy, done, err;
  logic [4:0] remaining;
  logic [4:0] outs;

  int pass_cnt = 0;
  int total_cnt = 0;

  assign outs = {busy, done, err, disp_d, disp_n};

  always #5 clk = ~clk;

  change_dispenser #(.ACK_TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .amount      (amount),
    .dime_empty  (dime_empty),
    .nickel_empty(nickel_empty),
    .coin_ack    (coin_ack),
    .clear       (clear),
    .disp_n      (disp_n),
    .disp_d      (disp_d),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .remaining   (remaining)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total_cnt++;
    if ({outs, remaining} !== 10'd0)
      $display("FAIL reset_state: outs/rem=%b/%0d required 00000/0", outs, remaining);
    else pass_cnt++;
    $display("test_reset: outs=%b remaining=%0d", outs, remaining);
  endtask

  task automatic test_mixed_payout();
    start = 1'b1; amount = 5'd3;
    tick();
    start = 1'b0;
    total_cnt++;
    if (outs !== 5'b10000 || remaining !== 5'd3)
      $display("FAIL mix_select: outs/rem=%b/%0d required 10000/3", outs, remaining);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (outs !== 5'b10010 || remaining !== 5'd3)
      $display("FAIL mix_dime_req: outs/rem=%b/%0d required 10010/3", outs, remaining);
    else pass_cnt++;
    dime_empty = 1'b1;
    tick();
    dime_empty = 1'b0;
    total_cnt++;
    if (outs !== 5'b10010)
      $display("FAIL mix_dime_held: outs=%b required 10010", outs);
    else pass_cnt++;
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    total_cnt++;
    if (outs !== 5'b10000 || remaining !== 5'd1)
      $display("FAIL mix_dime_ack: outs/rem=%b/%0d required 10000/1", outs, remaining);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (outs !== 5'b10001 || remaining !== 5'd1)
      $display("FAIL mix_nickel_req: outs/rem=%b/%0d required 10001/1", outs, remaining);
    else pass_cnt++;
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    total_cnt++;
    if (outs !== 5'b10000 || remaining !== 5'd0)
      $display("FAIL mix_nickel_ack: outs/rem=%b/%0d required 10000/0", outs, remaining);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (outs !== 5'b11000 || remaining !== 5'd0)
      $display("FAIL mix_done: outs/rem=%b/%0d required 11000/0", outs, remaining);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (outs !== 5'b00000)
      $display("FAIL mix_idle: outs=%b required 00000", outs);
    else pass_cnt++;
    $display("test_mixed_payout: amount=3 finished outs=%b remaining=%0d", outs, remaining);
  endtask

  task automatic test_nickels_only();
    dime_empty = 1'b1;
    start = 1'b1; amount = 5'd4;
    tick();
    start = 1'b0;
    total_cnt++;
    if (remaining !== 5'd4)
      $display("FAIL nick_load: remaining=%0d required 4", remaining);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (outs !== 5'b10001)
        $display("FAIL nick_req%0d: outs=%b required 10001", i, outs);
      else pass_cnt++;
      coin_ack = 1'b1;
      tick();
      coin_ack = 1'b0;
      total_cnt++;
      if (remaining !== 5'(3 - i))
        $display("FAIL nick_rem%0d: remaining=%0d required %0d", i, remaining, 3 - i);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (outs !== 5'b11000)
      $display("FAIL nick_done: outs=%b required 11000", outs);
    else pass_cnt++;
    tick();
    dime_empty = 1'b0;
    $display("test_nickels_only: amount=4 finished outs=%b", outs);
  endtask

  task automatic test_timeout();
    start = 1'b1; amount = 5'd2;
    tick();
    tick();
    total_cnt++;
    if (outs !== 5'b10010)
      $display("FAIL to_req: outs=%b required 10010", outs);
    else pass_cnt++;
    // start held high with a new amount must be ignored while busy
    amount = 5'd9;
    for (int i = 0; i < 14; i++) tick();
    start = 1'b0;
    total_cnt++;
    if (outs !== 5'b10010 || remaining !== 5'd2)
      $display("FAIL to_pre_limit: outs/rem=%b/%0d required 10010/2", outs, remaining);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (outs !== 5'b10100 || remaining !== 5'd2)
      $display("FAIL to_error: outs/rem=%b/%0d required 10100/2", outs, remaining);
    else pass_cnt++;
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    tick();
    total_cnt++;
    if (outs !== 5'b10100 || remaining !== 5'd2)
      $display("FAIL to_held: outs/rem=%b/%0d required 10100/2", outs, remaining);
    else pass_cnt++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total_cnt++;
    if (outs !== 5'b00000)
      $display("FAIL to_clear: outs=%b required 00000", outs);
    else pass_cnt++;
    $display("test_timeout: amount=2 no ack, cleared outs=%b", outs);
  endtask

  task automatic test_ack_at_limit();
    start = 1'b1; amount = 5'd2;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 14; i++) tick();
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    total_cnt++;
    if (outs !== 5'b10000 || remaining !== 5'd0)
      $display("FAIL limit_ack_wins: outs/rem=%b/%0d required 10000/0", outs, remaining);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (outs !== 5'b11000)
      $display("FAIL limit_done: outs=%b required 11000", outs);
    else pass_cnt++;
    tick();
    $display("test_ack_at_limit: ack on timeout cycle, outs=%b", outs);
  endtask

  task automatic test_nickel_empty();
    nickel_empty = 1'b1;
    start = 1'b1; amount = 5'd1;
    tick();
    start = 1'b0;
    tick();
    total_cnt++;
    if (outs !== 5'b10100 || remaining !== 5'd1)
      $display("FAIL ne_error: outs/rem=%b/%0d required 10100/1", outs, remaining);
    else pass_cnt++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    nickel_empty = 1'b0;
    total_cnt++;
    if (outs !== 5'b00000)
      $display("FAIL ne_clear: outs=%b required 00000", outs);
    else pass_cnt++;
    $display("test_nickel_empty: amount=1 faulted and cleared, outs=%b", outs);
  endtask

  task automatic test_zero_amount();
    start = 1'b1; amount = 5'd0;
    tick();
    start = 1'b0;
    total_cnt++;
    if (outs !== 5'b11000 || remaining !== 5'd0)
      $display("FAIL zero_done: outs/rem=%b/%0d required 11000/0", outs, remaining);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (outs !== 5'b00000)
      $display("FAIL zero_idle: outs=%b required 00000", outs);
    else pass_cnt++;
    $display("test_zero_amount: outs=%b", outs);
  endtask

  task automatic test_reset_mid_wait();
    start = 1'b1; amount = 5'd2;
    tick();
    start = 1'b0;
    tick();
    total_cnt++;
    if (outs !== 5'b10010)
      $display("FAIL rst_req: outs=%b required 10010", outs);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if ({outs, remaining} !== 10'd0)
      $display("FAIL rst_mid: outs/rem=%b/%0d required 00000/0", outs, remaining);
    else pass_cnt++;
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    tick();
    total_cnt++;
    if ({outs, remaining} !== 10'd0)
      $display("FAIL rst_late_ack: outs/rem=%b/%0d required 00000/0", outs, remaining);
    else pass_cnt++;
    $display("test_reset_mid_wait: outs=%b remaining=%0d", outs, remaining);
  endtask

  initial begin
    test_reset();
    test_mixed_payout();
    test_nickels_only();
    test_timeout();
    test_ack_at_limit();
    test_nickel_empty();
    test_zero_amount();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t exceeded, required finish before 100000", $time);
    $fatal(1);
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 15, which is the maximum cycles spent waiting for a coin_ack before faulting (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to pay out change; sampled only in IDLE.
REQ-005 SHALL have port amount, input, 5 bits: change owed, in nickel units (0..31); sampled with start.
REQ-006 SHALL have port dime_empty, input, 1 bit: dime hopper has no stock.
REQ-007 SHALL have port nickel_empty, input, 1 bit: nickel hopper has no stock.
REQ-008 SHALL have port coin_ack, input, 1 bit: hopper confirms that the requested coin has dropped.
REQ-009 SHALL have port clear, input, 1 bit: leave the ERROR state.
REQ-010 SHALL have port disp_n, output, 1 bit: eject-nickel request; level held until acked.
REQ-011 SHALL have port disp_d, output, 1 bit: eject-dime request; level held until acked.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when payout completes.
REQ-014 SHALL have port err, output, 1 bit: high while in ERROR.
REQ-015 SHALL have port remaining, output, 5 bits: nickel units still owed.

Function
REQ-016 SHALL implement the FSM states IDLE, SELECT, WAIT_ACK, DONE and ERROR, with all outputs registered.
REQ-017 IDLE: when start=1, SHALL load remaining<=amount and go to SELECT; if amount=0, SHALL go directly to DONE.
REQ-018 SELECT (one cycle): remaining=0 SHALL go to DONE; remaining>=2 and !dime_empty SHALL set disp_d and go to WAIT_ACK; otherwise, if remaining>=1 and !nickel_empty, SHALL set disp_n and go to WAIT_ACK; otherwise SHALL go to ERROR.
REQ-019 Only one of disp_n and disp_d SHALL be high at any time; both SHALL be low outside WAIT_ACK.
REQ-020 WAIT_ACK: on coin_ack=1, SHALL subtract 2 (dime) or 1 (nickel) from remaining, clear the disp_* output, clear the timer, and go to SELECT.
REQ-021 WAIT_ACK: the timer SHALL increment every cycle without an ack; when it reaches ACK_TIMEOUT, the FSM SHALL go to ERROR with the disp_* output cleared.
REQ-022 When coin_ack arrives in the same cycle the timer reaches ACK_TIMEOUT, the ack SHALL win.
REQ-023 coin_ack outside WAIT_ACK SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-024 DONE: SHALL assert done for exactly one cycle, then return to IDLE; remaining SHALL equal 0.
REQ-025 ERROR: err SHALL be held at 1 and remaining SHALL be frozen at the unpaid amount; clear=1 SHALL return the FSM to IDLE with err=0 on the next cycle.
REQ-026 remaining SHALL never underflow; a dime SHALL be selected only when remaining>=2.
REQ-027 Hopper-empty flags SHALL be evaluated in SELECT only; a flag change during WAIT_ACK SHALL not affect the pending coin.

Reset
REQ-028 When reset=1 at a clk edge, the block SHALL enter IDLE with disp_n=0, disp_d=0, busy=0, done=0, err=0, remaining=0 and timer=0.
REQ-029 Reset SHALL take priority over every input, including during WAIT_ACK and ERROR; a pending coin request SHALL be dropped.

Structure
REQ-030 Package change_pkg SHALL hold the state enum, NICKEL_UNITS=1, DIME_UNITS=2 and the default ACK_TIMEOUT.
REQ-031 The ack timeout counter SHALL be a sub-module named ack_timer (inputs: clk, reset, run, clr; output: expired).

Verification
REQ-032 The bench SHALL drive start with amount=3, both hoppers stocked, and ack each request -> disp_d then disp_n, then done pulses once, remaining 3->1->0.
REQ-033 The bench SHALL drive amount=4 with dime_empty=1 -> four disp_n requests and no disp_d, then done.
REQ-034 The bench SHALL drive amount=2 with no coin_ack for 15 cycles -> err=1, remaining=2, disp_d=0; then clear=1 -> IDLE, err=0.
REQ-035 The bench SHALL drive amount=1 with nickel_empty=1 -> ERROR with remaining=1, and no disp_* ever asserted.
REQ-036 The bench SHALL drive start with amount=0 -> done pulses, busy=1 for one cycle only, and no disp_* asserted.
REQ-037 The bench SHALL assert reset mid-WAIT_ACK with disp_d=1 -> next cycle all outputs 0 and state IDLE; a late coin_ack SHALL be ignored.
